// File: rtl/seq_det_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_pkg: shared types and defaults for the 1101 detector count path. Rev 1.0
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int SEQ_WIN_LEN = 16;
  localparam int SEQ_CNT_W   = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_result_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_result_reg: valid/ready result holding register with drop reporting. Rev 1.0
// ---------------------------------------------------------------------------
module seq_det_result_reg
  import seq_det_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             load_sat,
  input  logic             ready,
  output logic [CNT_W-1:0] data,
  output logic             sat,
  output logic             valid,
  output logic             drop
);

  logic [CNT_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // A load may reuse the slot that is being drained in the same cycle.
  always_comb begin
    accept  = valid_q & ready;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (load) begin
      if (!valid_q || accept) begin
        data_d  = load_data;
        sat_d   = load_sat;
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  assign data  = data_q;
  assign sat   = sat_q;
  assign valid = valid_q;
  assign drop  = drop_q;

endmodule : seq_det_result_reg
`default_nettype wire

// File: rtl/seq_det_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_counter: counts detector strobes over fixed windows, hands off counts. Rev 1.0
// ---------------------------------------------------------------------------
module seq_det_counter
  import seq_det_pkg::*;
#(
  parameter int WIN_LEN = SEQ_WIN_LEN,
  parameter int CNT_W   = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             det,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             drop
);

  localparam int               WC_W     = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_acc_q, sat_acc_d;

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] final_cnt;
  logic             final_sat;
  logic             win_close;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = COUNT;
      COUNT:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The extra sum bit flags an attempted overflow; sticky for the window.
  always_comb begin
    sum       = {1'b0, acc_q} + (CNT_W + 1)'(det);
    final_cnt = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    final_sat = sat_acc_q | sum[CNT_W];
    win_close = (state_q == COUNT) && (win_cnt_q == WIN_LAST);
    acc_d     = '0;
    sat_acc_d = 1'b0;
    win_cnt_d = '0;
    if ((state_q == COUNT) && enable && !win_close) begin
      acc_d     = final_cnt;
      sat_acc_d = final_sat;
      win_cnt_d = win_cnt_q + WC_W'(1);
    end
  end

  seq_det_result_reg #(
    .CNT_W(CNT_W)
  ) u_result_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (win_close),
    .load_data(final_cnt),
    .load_sat (final_sat),
    .ready    (cnt_ready),
    .data     (cnt_data),
    .sat      (cnt_sat),
    .valid    (cnt_valid),
    .drop     (drop)
  );

endmodule : seq_det_counter
`default_nettype wire

// File: tb/tb_seq_det_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_det_counter: scoreboard bench for seq_det_counter (CNT_W=8 and CNT_W=3). Rev 1.0
// ---------------------------------------------------------------------------
module tb_seq_det_counter;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic det = 1'b0;
  logic cnt_ready = 1'b0;

  logic [SEQ_CNT_W-1:0] cnt_data;
  logic cnt_sat, cnt_valid, drop;
  logic [2:0] s_data;
  logic s_sat, s_valid, s_drop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
  } res_t;

  res_t exp_q[$];
  res_t exp_s_q[$];

  always #5 clk = ~clk;

  seq_det_counter #(.WIN_LEN(SEQ_WIN_LEN), .CNT_W(SEQ_CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .det(det),
    .cnt_data(cnt_data), .cnt_sat(cnt_sat), .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready), .drop(drop)
  );

  seq_det_counter #(.WIN_LEN(16), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .det(det),
    .cnt_data(s_data), .cnt_sat(s_sat), .cnt_valid(s_valid),
    .cnt_ready(cnt_ready), .drop(s_drop)
  );

  function automatic res_t model(input int n, input int maxv);
    res_t r;
    r.data = 8'((n > maxv) ? maxv : n);
    r.sat  = (n > maxv);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_main(output res_t e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic pop_small(output res_t e);
    if (exp_s_q.size() == 0) e = 'x;
    else e = exp_s_q.pop_front();
  endtask

  // Leaves the bench in the first COUNT cycle of a fresh window.
  task automatic start_count(input logic rdy);
    reset = 1'b0; enable = 1'b0; det = 1'b0; cnt_ready = rdy;
    exp_q.delete();
    exp_s_q.delete();
    tick();
    tick();
    reset = 1'b1; enable = 1'b1;
    tick();
  endtask

  task automatic run_window(input logic [15:0] m);
    for (int i = 0; i < 16; i++) begin
      det = m[i];
      tick();
    end
    det = 1'b0;
  endtask

  task automatic test_reset();
    res_t e;
    int   c;
    reset = 1'b0; enable = 1'b1; det = 1'b1; cnt_ready = 1'b0;
    exp_q.delete();
    repeat (3) begin
      tick();
      checks++;
      if ({cnt_valid, cnt_data, cnt_sat, drop} !== '0) begin
        errors++;
        $display("FAIL reset_state: valid=%b data=%0d sat=%b drop=%b, required all 0",
                 cnt_valid, cnt_data, cnt_sat, drop);
      end
    end
    exp_q.push_back(model(16, 255));
    reset = 1'b1;
    tick();
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cnt_valid === 1'b1) begin
        c = i;
        break;
      end
    end
    checks++;
    if (c != 16) begin
      errors++;
      $display("FAIL reset_latency: result after %0d cycles (0=none), required 16", c);
    end
    pop_main(e);
    checks++;
    if ({cnt_data, cnt_sat} !== {e.data, e.sat}) begin
      errors++;
      $display("FAIL reset_first_result: data=%0d sat=%b, required data=%0d sat=%b",
               cnt_data, cnt_sat, e.data, e.sat);
    end
  endtask

  task automatic test_basic();
    res_t e;
    logic [15:0] m2 = 16'h0003;
    start_count(1'b1);
    exp_q.push_back(model(3, 255));
    run_window(16'h8088);
    pop_main(e);
    checks++;
    if ({cnt_valid, cnt_data, cnt_sat} !== {1'b1, e.data, e.sat}) begin
      errors++;
      $display("FAIL basic_count: valid=%b data=%0d sat=%b, required valid=1 data=%0d sat=%b",
               cnt_valid, cnt_data, cnt_sat, e.data, e.sat);
    end
    exp_q.push_back(model(2, 255));
    for (int i = 0; i < 16; i++) begin
      det = m2[i];
      tick();
      if (i == 0) begin
        checks++;
        if (cnt_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_one_cycle: valid=%b after transfer, required 0", cnt_valid);
        end
      end
    end
    det = 1'b0;
    pop_main(e);
    checks++;
    if ({cnt_valid, cnt_data, cnt_sat} !== {1'b1, e.data, e.sat}) begin
      errors++;
      $display("FAIL basic_no_gap: valid=%b data=%0d sat=%b, required valid=1 data=%0d sat=%b",
               cnt_valid, cnt_data, cnt_sat, e.data, e.sat);
    end
  endtask

  task automatic test_saturation();
    res_t e;
    start_count(1'b1);
    exp_s_q.push_back(model(16, 7));
    run_window(16'hFFFF);
    pop_small(e);
    checks++;
    if ({s_valid, s_data, s_sat} !== {1'b1, e.data[2:0], e.sat}) begin
      errors++;
      $display("FAIL sat_full: valid=%b data=%0d sat=%b, required valid=1 data=%0d sat=%b",
               s_valid, s_data, s_sat, e.data, e.sat);
    end
    exp_s_q.push_back(model(2, 7));
    run_window(16'h0101);
    pop_small(e);
    checks++;
    if ({s_valid, s_data, s_sat} !== {1'b1, e.data[2:0], e.sat}) begin
      errors++;
      $display("FAIL sat_clear: valid=%b data=%0d sat=%b, required valid=1 data=%0d sat=%b",
               s_valid, s_data, s_sat, e.data, e.sat);
    end
  endtask

  task automatic test_backpressure();
    res_t e;
    logic bad = 1'b0;
    logic [15:0] mb = 16'h001F;
    start_count(1'b0);
    exp_q.push_back(model(2, 255));
    run_window(16'h0011);
    for (int i = 0; i < 16; i++) begin
      det = mb[i];
      tick();
      if (i < 15 && drop !== 1'b0) bad = 1'b1;
    end
    det = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_early_drop: drop seen during window B, required 0");
    end
    pop_main(e);
    checks++;
    if ({drop, cnt_valid, cnt_data} !== {1'b1, 1'b1, e.data}) begin
      errors++;
      $display("FAIL bp_drop: drop=%b valid=%b data=%0d, required drop=1 valid=1 data=%0d",
               drop, cnt_valid, cnt_data, e.data);
    end
    tick();
    checks++;
    if ({drop, cnt_valid, cnt_data} !== {1'b0, 1'b1, e.data}) begin
      errors++;
      $display("FAIL bp_drop_pulse: drop=%b valid=%b data=%0d, required drop=0 valid=1 data=%0d",
               drop, cnt_valid, cnt_data, e.data);
    end
    cnt_ready = 1'b1;
    tick();
    checks++;
    if (cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b after single transfer, required 0", cnt_valid);
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    logic [15:0] m2 = 16'h003F;
    start_count(1'b0);
    exp_q.push_back(model(4, 255));
    run_window(16'h000F);
    pop_main(e);
    checks++;
    if ({cnt_valid, cnt_data} !== {1'b1, e.data}) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%0d, required valid=1 data=%0d",
               cnt_valid, cnt_data, e.data);
    end
    exp_q.push_back(model(6, 255));
    for (int i = 0; i < 16; i++) begin
      det = m2[i];
      cnt_ready = (i == 15);
      tick();
    end
    det = 1'b0;
    cnt_ready = 1'b0;
    pop_main(e);
    checks++;
    if ({cnt_valid, drop, cnt_data, cnt_sat} !== {1'b1, 1'b0, e.data, e.sat}) begin
      errors++;
      $display("FAIL b2b_accept_load: valid=%b drop=%b data=%0d sat=%b, required valid=1 drop=0 data=%0d sat=%b",
               cnt_valid, drop, cnt_data, cnt_sat, e.data, e.sat);
    end
  endtask

  task automatic test_abort();
    res_t e;
    logic bad = 1'b0;
    int   c;
    start_count(1'b0);
    exp_q.push_back(model(1, 255));
    run_window(16'h0001);
    for (int i = 0; i < 10; i++) begin
      det = (i < 4);
      enable = (i != 9);
      tick();
    end
    det = 1'b0;
    enable = 1'b0;
    repeat (20) begin
      tick();
      if (drop !== 1'b0 || cnt_valid !== 1'b1 || cnt_data !== 8'd1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_idle: drop=%b valid=%b data=%0d, required drop=0 valid=1 data=1 throughout",
               drop, cnt_valid, cnt_data);
    end
    pop_main(e);
    checks++;
    if ({cnt_valid, cnt_data} !== {1'b1, e.data}) begin
      errors++;
      $display("FAIL abort_pending: valid=%b data=%0d, required valid=1 data=%0d",
               cnt_valid, cnt_data, e.data);
    end
    cnt_ready = 1'b1;
    tick();
    checks++;
    if (cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_drain: valid=%b, required 0", cnt_valid);
    end
    enable = 1'b1;
    exp_q.push_back(model(1, 255));
    tick();
    c = 0;
    for (int i = 0; i < 24; i++) begin
      det = (i == 2);
      tick();
      if (cnt_valid === 1'b1) begin
        c = i + 1;
        break;
      end
    end
    det = 1'b0;
    checks++;
    if (c != 16) begin
      errors++;
      $display("FAIL restart_latency: result after %0d cycles (0=none), required 16", c);
    end
    pop_main(e);
    checks++;
    if ({cnt_data, cnt_sat} !== {e.data, e.sat}) begin
      errors++;
      $display("FAIL restart_count: data=%0d sat=%b, required data=%0d sat=%b",
               cnt_data, cnt_sat, e.data, e.sat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_det_counter
`default_nettype wire
